// File: rtl/fetch_ifid_stage_pkg.sv
// fetch_ifid_stage_pkg: shared widths, fetch FSM states and the halt opcode for the fetch stage.
package fetch_ifid_stage_pkg;
    localparam int ADDRESS_LEN     = 9;
    localparam int INSTRUCTION_LEN = 16;
    localparam int WORD_LEN        = 16;
    localparam logic [3:0] OPCODE_HALT = 4'hF;
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_ifid_stage_load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect (
    input  logic       pr1_valid_i,
    input  logic       pr2_mem_read_i,
    input  logic [2:0] pr2_dst_i,
    input  logic [2:0] id_src1_i,
    input  logic [2:0] id_src2_i,
    input  logic       id_src2_used_i,
    output logic       load_use_o
);
    always_comb begin
        load_use_o = pr1_valid_i & pr2_mem_read_i &
                     ((pr2_dst_i == id_src1_i) | (id_src2_used_i & (pr2_dst_i == id_src2_i)));
    end
endmodule

// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: PC, instruction fetch and IF/ID register with load-use stall, redirect and halt.
module fetch_ifid_stage
    import fetch_ifid_stage_pkg::*;
#(
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0,
    parameter logic [3:0]             HALT_OPCODE = OPCODE_HALT
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDRESS_LEN-1:0]     imem_addr,
    input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
    input  logic                       br_taken,
    input  logic [ADDRESS_LEN-1:0]     br_target,
    input  logic [2:0]                 id_src1,
    input  logic [2:0]                 id_src2,
    input  logic                       id_src2_used,
    input  logic                       PR2_MEM_read,
    input  logic [2:0]                 PR2_dst,
    output logic [INSTRUCTION_LEN-1:0] PR1_instruction,
    output logic [ADDRESS_LEN-1:0]     PR1_PC_plus_one,
    output logic                       PR1_valid,
    output logic                       flush_id_ex,
    output logic                       halted
);
    logic [ADDRESS_LEN-1:0]     pc_q, pc_d, ppo_q, ppo_d, pc_inc;
    logic [INSTRUCTION_LEN-1:0] ir_q, ir_d;
    logic                       valid_q, valid_d, load_use;
    fetch_state_t               state_q, state_d;

    load_use_detect u_lud (
        .pr1_valid_i    (valid_q),
        .pr2_mem_read_i (PR2_MEM_read),
        .pr2_dst_i      (PR2_dst),
        .id_src1_i      (id_src1),
        .id_src2_i      (id_src2),
        .id_src2_used_i (id_src2_used),
        .load_use_o     (load_use)
    );

    assign imem_addr       = pc_q;
    assign pc_inc          = pc_q + 1'b1;
    assign PR1_instruction = ir_q;
    assign PR1_PC_plus_one = ppo_q;
    assign PR1_valid       = valid_q;
    assign halted          = (state_q == HALT);
    assign flush_id_ex     = load_use & ~rst;

    // Stall beats redirect: the branch operands may depend on the stalled load.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        ppo_d   = ppo_q;
        valid_d = valid_q;
        state_d = state_q;
        if (load_use) begin
            pc_d = pc_q;
        end else if (br_taken) begin
            pc_d    = br_target;
            ir_d    = '0;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (state_q == HALT) begin
            ir_d    = '0;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_inc;
            ir_d    = imem_rdata;
            ppo_d   = pc_inc;
            valid_d = 1'b1;
            state_d = (imem_rdata[INSTRUCTION_LEN-1 -: 4] == HALT_OPCODE) ? HALT : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ppo_q   <= '0;
            valid_q <= 1'b0;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ppo_q   <= ppo_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb_fetch_ifid_stage: directed scenarios for fetch, stall, redirect, halt, reset and PC wrap.
module tb_fetch_ifid_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        br_taken;
    logic [8:0]  br_target;
    logic [2:0]  id_src1, id_src2, PR2_dst;
    logic        id_src2_used, PR2_MEM_read;
    logic [15:0] PR1_instruction;
    logic [8:0]  PR1_PC_plus_one;
    logic        PR1_valid, flush_id_ex, halted;
    logic [15:0] rom [0:511];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign imem_rdata = rom[imem_addr];

    fetch_ifid_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .br_taken(br_taken), .br_target(br_target), .id_src1(id_src1), .id_src2(id_src2),
        .id_src2_used(id_src2_used), .PR2_MEM_read(PR2_MEM_read), .PR2_dst(PR2_dst),
        .PR1_instruction(PR1_instruction), .PR1_PC_plus_one(PR1_PC_plus_one),
        .PR1_valid(PR1_valid), .flush_id_ex(flush_id_ex), .halted(halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [8:0] pc, input logic [15:0] ir,
                                input logic v, input logic h);
        checks++;
        if (imem_addr !== pc || PR1_instruction !== ir || PR1_valid !== v || halted !== h) begin
            errors++;
            $display("FAIL %s: pc=%h ir=%h v=%b h=%b, expected pc=%h ir=%h v=%b h=%b",
                     name, imem_addr, PR1_instruction, PR1_valid, halted, pc, ir, v, h);
        end
    endtask

    task automatic redirect(input logic [8:0] tgt);
        br_taken = 1'b1; br_target = tgt;
        step();
        br_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        expect_state("reset", 9'h000, 16'h0000, 1'b0, 1'b0);
        checks++;
        if (PR1_PC_plus_one !== 9'h000 || flush_id_ex !== 1'b0) begin
            errors++;
            $display("FAIL reset_ppo_flush: ppo=%h flush=%b, expected 000 0", PR1_PC_plus_one, flush_id_ex);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        for (int i = 1; i <= 3; i++) begin
            step();
            expect_state($sformatf("fetch%0d", i), 9'(i), 16'(16'h0100 + i - 1), 1'b1, 1'b0);
            checks++;
            if (PR1_PC_plus_one !== 9'(i)) begin
                errors++;
                $display("FAIL fetch_ppo%0d: got %h expected %h", i, PR1_PC_plus_one, 9'(i));
            end
        end
    endtask

    task automatic test_load_use();
        PR2_MEM_read = 1'b1; PR2_dst = 3'd3; id_src1 = 3'd3;
        #1;
        checks++;
        if (flush_id_ex !== 1'b1) begin
            errors++;
            $display("FAIL stall_flush: got %b expected 1", flush_id_ex);
        end
        step();
        PR2_MEM_read = 1'b0;
        expect_state("stall_hold", 9'h003, 16'h0102, 1'b1, 1'b0);
        #1;
        checks++;
        if (flush_id_ex !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got %b expected 0", flush_id_ex);
        end
        PR2_MEM_read = 1'b1; PR2_dst = 3'd5; id_src1 = 3'd0; id_src2 = 3'd5; id_src2_used = 1'b0;
        #1;
        checks++;
        if (flush_id_ex !== 1'b0) begin
            errors++;
            $display("FAIL src2_unused: got %b expected 0", flush_id_ex);
        end
        id_src2_used = 1'b1;
        #1;
        checks++;
        if (flush_id_ex !== 1'b1) begin
            errors++;
            $display("FAIL src2_used: got %b expected 1", flush_id_ex);
        end
        PR2_MEM_read = 1'b0; id_src2_used = 1'b0; id_src1 = 3'd3; PR2_dst = 3'd3;
        step();
        expect_state("after_stall", 9'h004, 16'h0103, 1'b1, 1'b0);
    endtask

    task automatic test_redirect();
        step();
        expect_state("pre_branch", 9'h005, 16'h0104, 1'b1, 1'b0);
        redirect(9'h040);
        expect_state("branch_bubble", 9'h040, 16'h0000, 1'b0, 1'b0);
        step();
        expect_state("branch_target", 9'h041, 16'h0140, 1'b1, 1'b0);
    endtask

    task automatic test_stall_vs_branch();
        PR2_MEM_read = 1'b1; br_taken = 1'b1; br_target = 9'h060;
        step();
        expect_state("stall_wins", 9'h041, 16'h0140, 1'b1, 1'b0);
        PR2_MEM_read = 1'b0;
        step();
        br_taken = 1'b0;
        expect_state("late_redirect", 9'h060, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        rom[7] = 16'hF007;
        redirect(9'h005);
        step();
        expect_state("pre_halt1", 9'h006, 16'h0105, 1'b1, 1'b0);
        step();
        step();
        expect_state("halt_enter", 9'h008, 16'hF007, 1'b1, 1'b1);
        step();
        expect_state("halt_bubble1", 9'h008, 16'h0000, 1'b0, 1'b1);
        step();
        expect_state("halt_bubble2", 9'h008, 16'h0000, 1'b0, 1'b1);
        redirect(9'h020);
        expect_state("halt_exit", 9'h020, 16'h0000, 1'b0, 1'b0);
        step();
        expect_state("resume", 9'h021, 16'h0120, 1'b1, 1'b0);
        rom[9'h21] = 16'hF021;
        redirect(9'h030);
        rom[9'h21] = 16'h0121;
        expect_state("wrong_path_halt", 9'h030, 16'h0000, 1'b0, 1'b0);
        step();
        expect_state("wrong_path_resume", 9'h031, 16'h0130, 1'b1, 1'b0);
    endtask

    task automatic test_wrap_and_reset();
        redirect(9'h1FE);
        step();
        step();
        expect_state("wrap", 9'h000, 16'h02FF, 1'b1, 1'b0);
        checks++;
        if (PR1_PC_plus_one !== 9'h000) begin
            errors++;
            $display("FAIL wrap_ppo: got %h expected 000", PR1_PC_plus_one);
        end
        redirect(9'h1FE);
        step();
        PR2_MEM_read = 1'b1; rst = 1'b1;
        #1;
        checks++;
        if (flush_id_ex !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_rst: got %b expected 0", flush_id_ex);
        end
        step();
        rst = 1'b0; PR2_MEM_read = 1'b0;
        expect_state("rst_mid_stall", 9'h000, 16'h0000, 1'b0, 1'b0);
        step();
        expect_state("post_rst_fetch", 9'h001, 16'h0100, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 16'(16'h0100 + i);
        rst = 1'b1; br_taken = 1'b0; br_target = '0;
        id_src1 = 3'd3; id_src2 = 3'd0; id_src2_used = 1'b0;
        PR2_MEM_read = 1'b0; PR2_dst = 3'd3;
        #2;
        test_reset();
        test_fetch();
        test_load_use();
        test_redirect();
        test_stall_vs_branch();
        test_halt();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
